fft_stream_adapter: RTL and testbench
=====================================

Name: fft_stream_adapter

Overview:
- Streaming front/back end for a parallel N-point IEEE-754 single-precision FFT core with a start/done interface, such as FFT_8Points.
- Accepts one complex sample per cycle over valid/ready, assembles a frame of NUM_POINT samples and fires the core with one start pulse.
- Captures the parallel result and streams it out in natural order, one bin per cycle over valid/ready, with index and last flags.
- Adds an inverse mode: input conjugation, output conjugation and 1/N exponent scaling around the forward core.

Parameters:
- SIZE_DATA, 32, word width; only 32 (IEEE-754 single) is supported.
- NUM_POINT, 8, FFT length; power of 2, minimum 2.
- LOG2_N, $clog2(NUM_POINT), localparam; index width and scaling shift.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_mode  in  1  0 = forward, 1 = inverse; sampled when sample 0 of a frame is accepted.
- i_in_valid  in  1  input sample valid.
- o_in_ready  out  1  adapter accepts a sample this cycle.
- i_in_real  in  SIZE_DATA  sample real part.
- i_in_imag  in  SIZE_DATA  sample imaginary part.
- o_core_start  out  1  one-cycle start pulse to the core.
- o_core_x_real  out  NUM_POINT*SIZE_DATA  core inputs, real; sample k in bits [k*32 +: 32].
- o_core_x_imag  out  NUM_POINT*SIZE_DATA  core inputs, imaginary; same packing.
- i_core_X_real  in  NUM_POINT*SIZE_DATA  core outputs, real; same packing.
- i_core_X_imag  in  NUM_POINT*SIZE_DATA  core outputs, imaginary; same packing.
- i_core_done  in  1  core done; level signal, may stay high.
- o_out_valid  out  1  output bin valid.
- i_out_ready  in  1  downstream accepts the bin.
- o_out_real  out  SIZE_DATA  bin real part.
- o_out_imag  out  SIZE_DATA  bin imaginary part.
- o_out_index  out  LOG2_N  bin number.
- o_out_last  out  1  high with bin NUM_POINT-1.
- o_busy  out  1  high in every state except COLLECT.

Behaviour:
- Reset (i_rst_n low at an edge): state COLLECT; wr_idx, rd_idx, mode_q, done_d cleared. Outputs: o_in_ready 1 (after reset), o_core_start 0, o_out_valid 0, o_out_real/imag/index 0, o_out_last 0, o_busy 0. Reset mid-frame discards all partial data.
- FSM states: COLLECT, START, WAIT, EMIT.
- COLLECT:
  - o_in_ready=1.
  - On handshake, store sample at wr_idx. If mode is inverse, imag bit 31 is inverted (conjugation).
  - mode_q captured on the wr_idx==0 handshake.
  - Handshake at wr_idx==NUM_POINT-1 -> START, wr_idx back to 0.
- START: o_core_start=1 for exactly one cycle -> WAIT.
- Core inputs: o_core_x_* are driven from the frame buffer and stay stable from START until EMIT ends.
- WAIT:
  - done_d registers i_core_done every cycle.
  - A rising edge (i_core_done=1, done_d=0) captures both result buses into the output buffer -> EMIT.
  - o_out_valid is high the cycle after the edge.
  - A done level already high on WAIT entry must not trigger; a new rising edge is required.
- EMIT:
  - o_out_valid=1; outputs are taken from the buffer at rd_idx; o_out_index=rd_idx; o_out_last=(rd_idx==NUM_POINT-1).
  - rd_idx advances on valid&ready.
  - While valid&!ready, all out fields hold stable.
  - Handshake with last -> COLLECT, rd_idx=0; o_in_ready is high the next cycle.
- o_in_ready=0 in START/WAIT/EMIT; input data offered then is not consumed.
- i_core_done edges outside WAIT are ignored; done_d still tracks.
- Inverse output transform, applied to each part w:
  - Imag sign is flipped (conjugation).
  - Exponent e=w[30:23]:
    - e==0: pass w unchanged (signed zero or subnormal).
    - e==255: pass unchanged (Inf/NaN).
    - 1<=e<=LOG2_N: flush to signed zero, sign kept.
    - Otherwise: e-LOG2_N, mantissa unchanged.
- Forward mode: outputs are passed bit-exact from the core.
- Throughput: one frame per (NUM_POINT + 2 + core latency + NUM_POINT) cycles minimum; no overlap between frames.

Test Plan:
- Forward impulse, NUM_POINT=8, golden core model: x0=0x3F800000, others 0, continuous valid/ready -> 8 bins real 0x3F800000, imag 0x00000000, index 0..7, last only on index 7; exactly one o_core_start pulse.
- Inverse, all X real=0x3F800000: core sees x real 1.0, imag -0.0 -> outputs bin0 real 0x3F800000 (8.0 scaled by 1/8), other bins +/-0; bin0 imag is signed zero with sign flipped.
- Backpressure: i_out_ready pattern 1,0,0,1,0,1... -> each index 0..7 emitted exactly once, fields stable while stalled; input i_in_valid held high meanwhile -> o_in_ready stays 0 until the last bin is accepted.
- Scaling boundaries, inverse, NUM_POINT=8, forced core results:
  - 0x00800000 -> 0x00000000
  - 0x80800000 -> 0x80000000
  - 0x41000000 -> 0x3F800000
  - 0x7F800000 -> 0x7F800000
  - 0x00000001 -> 0x00000001
  - Imaginary parts additionally sign-inverted.
- Done handling: core holds done high across two frames, plus a spurious done pulse during COLLECT -> no capture until a fresh rising edge in WAIT; results correct for both frames.
- Reset mid-EMIT at index 3 -> next cycle o_out_valid=0, o_in_ready=1, o_busy=0; the following frame (NUM_POINT=16 build also run) produces correct results with index starting at 0.

Source files
------------

// File: rtl/fft_stream_adapter.sv
// -----------------------------------------------------------------------------
// fft_stream_adapter
//
// Streaming wrapper around a parallel NUM_POINT-point single-precision FFT core
// that has a start/done interface. Complex samples arrive one per cycle over
// valid/ready. They are gathered into a frame buffer, and the core is fired
// with one start pulse. The parallel result is captured on a fresh rising edge
// of done and streamed out in natural order, one bin per cycle, with an index
// and a last flag.
//
// Inverse mode reuses the forward core. The input is conjugated before the
// core. The output is conjugated and scaled by 1/N after the core, and the
// scaling subtracts LOG2_N from the IEEE-754 exponent.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), synchronous active-low reset
//   i_mode                    0 forward / 1 inverse, taken with sample 0
//   i_in_valid, o_in_ready    input handshake
//   i_in_real, i_in_imag      input sample
//   o_core_start              one-cycle start pulse to the core
//   o_core_x_real/imag        frame buffer to the core, sample k at [k*32 +: 32]
//   i_core_X_real/imag        core results, same packing
//   i_core_done               core done level
//   o_out_valid, i_out_ready  output handshake
//   o_out_real, o_out_imag    output bin
//   o_out_index, o_out_last   bin number and end-of-frame flag
//   o_busy                    high whenever no frame is being collected
// -----------------------------------------------------------------------------
module fft_stream_adapter #(
    parameter  int SIZE_DATA = 32,
    parameter  int NUM_POINT = 8,
    localparam int LOG2_N    = $clog2(NUM_POINT)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_mode,
    input  logic                           i_in_valid,
    output logic                           o_in_ready,
    input  logic [SIZE_DATA-1:0]           i_in_real,
    input  logic [SIZE_DATA-1:0]           i_in_imag,
    output logic                           o_core_start,
    output logic [NUM_POINT*SIZE_DATA-1:0] o_core_x_real,
    output logic [NUM_POINT*SIZE_DATA-1:0] o_core_x_imag,
    input  logic [NUM_POINT*SIZE_DATA-1:0] i_core_X_real,
    input  logic [NUM_POINT*SIZE_DATA-1:0] i_core_X_imag,
    input  logic                           i_core_done,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic [SIZE_DATA-1:0]           o_out_real,
    output logic [SIZE_DATA-1:0]           o_out_imag,
    output logic [LOG2_N-1:0]              o_out_index,
    output logic                           o_out_last,
    output logic                           o_busy
);

    localparam logic [LOG2_N-1:0] IDX_ZERO = {LOG2_N{1'b0}};
    localparam logic [LOG2_N-1:0] IDX_ONE  = {{(LOG2_N-1){1'b0}}, 1'b1};
    localparam logic [LOG2_N-1:0] IDX_LAST = LOG2_N'(NUM_POINT - 1);
    localparam logic [7:0]        SHIFT_E  = 8'(LOG2_N);
    localparam logic [SIZE_DATA-1:0] WORD_ZERO = {SIZE_DATA{1'b0}};

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

    // Conjugation of one part: only the sign bit changes.
    function automatic logic [SIZE_DATA-1:0] flip_sign(input logic [SIZE_DATA-1:0] w);
        flip_sign = {~w[31], w[30:0]};
    endfunction

    // Divide by NUM_POINT through the exponent. Zero/subnormal and Inf/NaN pass
    // through unchanged. Exponents too small to survive the shift flush to a
    // zero that keeps the sign.
    function automatic logic [SIZE_DATA-1:0] inv_scale(input logic [SIZE_DATA-1:0] w);
        logic [7:0] e;
        e = w[30:23];
        if ((e == 8'd0) || (e == 8'hFF)) begin
            inv_scale = w;
        end else if (e <= SHIFT_E) begin
            inv_scale = {w[31], 31'd0};
        end else begin
            inv_scale = {w[31], e - SHIFT_E, w[22:0]};
        end
    endfunction

    state_t                 state_r, next_state_s;
    logic [LOG2_N-1:0]      wr_idx_r, rd_idx_r, nxt_rd_idx_s;
    logic                   mode_q_r, done_d_r;
    logic                   in_ready_r, start_r, out_valid_r, out_last_r, busy_r;
    logic [SIZE_DATA-1:0]   out_real_r, out_imag_r;
    logic [SIZE_DATA-1:0]   in_re_r  [NUM_POINT];
    logic [SIZE_DATA-1:0]   in_im_r  [NUM_POINT];
    logic [SIZE_DATA-1:0]   out_re_r [NUM_POINT];
    logic [SIZE_DATA-1:0]   out_im_r [NUM_POINT];
    logic [SIZE_DATA-1:0]   res_re_s [NUM_POINT];
    logic [SIZE_DATA-1:0]   res_im_s [NUM_POINT];
    logic                   in_fire_s, out_fire_s, capture_s, eff_mode_s;
    logic [SIZE_DATA-1:0]   in_imag_s;

    assign in_fire_s    = in_ready_r & i_in_valid;
    assign out_fire_s   = out_valid_r & i_out_ready;
    // Only a fresh rising edge of done counts. A level left high from an
    // earlier frame is ignored.
    assign capture_s    = (state_r == ST_WAIT) & i_core_done & ~done_d_r;
    // Sample 0 uses the live mode pin. Every later sample uses the captured mode.
    assign eff_mode_s   = (wr_idx_r == IDX_ZERO) ? i_mode : mode_q_r;
    assign in_imag_s    = eff_mode_s ? flip_sign(i_in_imag) : i_in_imag;
    assign nxt_rd_idx_s = rd_idx_r + IDX_ONE;

    genvar g;
    generate
        for (g = 0; g < NUM_POINT; g++) begin : g_core_in
            assign o_core_x_real[g*SIZE_DATA +: SIZE_DATA] = in_re_r[g];
            assign o_core_x_imag[g*SIZE_DATA +: SIZE_DATA] = in_im_r[g];
        end
    endgenerate

    assign o_in_ready   = in_ready_r;
    assign o_core_start = start_r;
    assign o_out_valid  = out_valid_r;
    assign o_out_real   = out_real_r;
    assign o_out_imag   = out_imag_r;
    assign o_out_index  = rd_idx_r;
    assign o_out_last   = out_last_r;
    assign o_busy       = busy_r;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (in_fire_s && (wr_idx_r == IDX_LAST)) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_COLLECT;
                end
            end
            ST_START: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (capture_s) begin
                    next_state_s = ST_EMIT;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_EMIT: begin
                if (out_fire_s && out_last_r) begin
                    next_state_s = ST_COLLECT;
                end else begin
                    next_state_s = ST_EMIT;
                end
            end
            default: next_state_s = ST_COLLECT;
        endcase
    end

    // Result transform: pass-through when forward, conjugate and 1/N scale when inverse.
    always_comb begin
        for (int k = 0; k < NUM_POINT; k++) begin
            res_re_s[k] = i_core_X_real[k*SIZE_DATA +: SIZE_DATA];
            res_im_s[k] = i_core_X_imag[k*SIZE_DATA +: SIZE_DATA];
            if (mode_q_r) begin
                res_re_s[k] = inv_scale(i_core_X_real[k*SIZE_DATA +: SIZE_DATA]);
                res_im_s[k] = inv_scale(flip_sign(i_core_X_imag[k*SIZE_DATA +: SIZE_DATA]));
            end else begin
                res_re_s[k] = i_core_X_real[k*SIZE_DATA +: SIZE_DATA];
                res_im_s[k] = i_core_X_imag[k*SIZE_DATA +: SIZE_DATA];
            end
        end
    end

    // Datapath: frame buffer, result buffer, output registers and handshake flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_idx_r    <= IDX_ZERO;
            rd_idx_r    <= IDX_ZERO;
            mode_q_r    <= 1'b0;
            done_d_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            start_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_real_r  <= WORD_ZERO;
            out_imag_r  <= WORD_ZERO;
            for (int k = 0; k < NUM_POINT; k++) begin
                in_re_r[k]  <= WORD_ZERO;
                in_im_r[k]  <= WORD_ZERO;
                out_re_r[k] <= WORD_ZERO;
                out_im_r[k] <= WORD_ZERO;
            end
        end else begin
            done_d_r    <= i_core_done;
            // Handshake flags are registered copies of the next state.
            in_ready_r  <= (next_state_s == ST_COLLECT);
            busy_r      <= (next_state_s != ST_COLLECT);
            start_r     <= (next_state_s == ST_START);
            out_valid_r <= (next_state_s == ST_EMIT);

            if (in_fire_s) begin
                in_re_r[wr_idx_r] <= i_in_real;
                in_im_r[wr_idx_r] <= in_imag_s;
                if (wr_idx_r == IDX_ZERO) begin
                    mode_q_r <= i_mode;
                end
                wr_idx_r <= (wr_idx_r == IDX_LAST) ? IDX_ZERO : (wr_idx_r + IDX_ONE);
            end

            if (capture_s) begin
                for (int k = 0; k < NUM_POINT; k++) begin
                    out_re_r[k] <= res_re_s[k];
                    out_im_r[k] <= res_im_s[k];
                end
                rd_idx_r   <= IDX_ZERO;
                out_real_r <= res_re_s[0];
                out_imag_r <= res_im_s[0];
                out_last_r <= 1'b0;
            end else if (out_fire_s) begin
                if (out_last_r) begin
                    rd_idx_r   <= IDX_ZERO;
                    out_last_r <= 1'b0;
                end else begin
                    rd_idx_r   <= nxt_rd_idx_s;
                    out_real_r <= out_re_r[nxt_rd_idx_s];
                    out_imag_r <= out_im_r[nxt_rd_idx_s];
                    out_last_r <= (nxt_rd_idx_s == IDX_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_fft_stream_adapter
//
// Directed bench for fft_stream_adapter with NUM_POINT=8. The FFT core is
// replaced by driving hand-computed result vectors onto the core result buses
// and toggling done. Each case also checks the frame buffer the adapter
// presents to the core.
// -----------------------------------------------------------------------------
module tb_fft_stream_adapter;

    localparam int NP = 8;
    localparam int W  = 32;
    localparam int LN = $clog2(NP);

    logic               i_clk = 1'b0;
    logic               i_rst_n, i_mode, i_in_valid, i_core_done, i_out_ready;
    logic [W-1:0]       i_in_real, i_in_imag;
    logic [NP*W-1:0]    i_core_X_real, i_core_X_imag;
    logic               o_in_ready, o_core_start, o_out_valid, o_out_last, o_busy;
    logic [NP*W-1:0]    o_core_x_real, o_core_x_imag;
    logic [W-1:0]       o_out_real, o_out_imag;
    logic [LN-1:0]      o_out_index;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    bit cur_mode;
    logic [W-1:0] in_re [NP];
    logic [W-1:0] in_im [NP];
    logic [W-1:0] cx_re [NP];
    logic [W-1:0] cx_im [NP];
    logic [W-1:0] exp_re [NP];
    logic [W-1:0] exp_im [NP];

    always #5 i_clk = ~i_clk;

    fft_stream_adapter #(.SIZE_DATA(W), .NUM_POINT(NP)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_real(i_in_real), .i_in_imag(i_in_imag),
        .o_core_start(o_core_start),
        .o_core_x_real(o_core_x_real), .o_core_x_imag(o_core_x_imag),
        .i_core_X_real(i_core_X_real), .i_core_X_imag(i_core_X_imag),
        .i_core_done(i_core_done),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_real(o_out_real), .o_out_imag(o_out_imag),
        .o_out_index(o_out_index), .o_out_last(o_out_last), .o_busy(o_busy)
    );

    // Count every start pulse the adapter issues.
    always @(posedge i_clk) begin
        if (o_core_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Offer one frame from in_re/in_im. Only sample 0 carries the wanted mode.
    task automatic send_frame(input bit mode, input bit spurious);
        int n;
        cur_mode = mode;
        for (int k = 0; k < NP; k++) begin
            i_in_valid = 1'b1;
            i_in_real  = in_re[k];
            i_in_imag  = in_im[k];
            i_mode     = (k == 0) ? mode : ~mode;
            if (spurious && k == 3) i_core_done = 1'b1;
            if (spurious && k == 4) i_core_done = 1'b0;
            if (spurious && k == 5) i_core_done = 1'b1;
            n = 0;
            while (!o_in_ready && n < 50) begin
                step();
                n++;
            end
            if (n == 50) chk("in_ready_timeout", 32'd0, 32'd1);
            step();
        end
        i_in_valid = 1'b0;
    endtask

    // Stand-in for the core: wait for start, check its inputs, drive results, raise done.
    task automatic core_respond(input bit hold);
        int n;
        logic [W-1:0] xi;
        n = 0;
        while (!o_core_start && n < 50) begin
            step();
            n++;
        end
        if (n == 50) chk("start_timeout", 32'd0, 32'd1);
        chk("busy_in_start", 32'(o_busy), 32'd1);
        chk("in_ready_in_start", 32'(o_in_ready), 32'd0);
        for (int k = 0; k < NP; k++) begin
            xi = in_im[k];
            if (cur_mode) xi[31] = ~xi[31];
            chk("core_x_re", o_core_x_real[k*W +: W], in_re[k]);
            chk("core_x_im", o_core_x_imag[k*W +: W], xi);
        end
        step();
        chk("start_one_cycle", 32'(o_core_start), 32'd0);
        step();
        step();
        chk("no_early_capture", 32'(o_out_valid), 32'd0);
        for (int k = 0; k < NP; k++) begin
            i_core_X_real[k*W +: W] = cx_re[k];
            i_core_X_imag[k*W +: W] = cx_im[k];
        end
        i_core_done = 1'b0;
        step();
        i_core_done = 1'b1;
        step();
        chk("valid_after_edge", 32'(o_out_valid), 32'd1);
        if (!hold) i_core_done = 1'b0;
    endtask

    // Drain the output stream against exp_re/exp_im. A stop_at >= 0 leaves
    // the task as soon as that bin is presented.
    task automatic recv(input bit bp, input bit chk_rdy, input int stop_at);
        int idx, n;
        bit r, v;
        logic [5:0] pat;
        pat = 6'b101001;
        idx = 0;
        n = 0;
        while (idx < NP && n < 300) begin
            if (o_out_valid) begin
                if (idx == stop_at) begin
                    i_out_ready = 1'b0;
                    return;
                end
                chk("out_real", o_out_real, exp_re[idx]);
                chk("out_imag", o_out_imag, exp_im[idx]);
                chk("out_index", 32'(o_out_index), 32'(idx));
                chk("out_last", 32'(o_out_last), 32'(idx == NP - 1));
                if (chk_rdy) chk("in_ready_emit", 32'(o_in_ready), 32'd0);
            end
            r = bp ? pat[n % 6] : 1'b1;
            v = o_out_valid;
            i_out_ready = r;
            step();
            n++;
            if (v && r) idx++;
        end
        i_out_ready = 1'b0;
        chk("recv_count", 32'(idx), 32'(NP));
        chk("in_ready_after", 32'(o_in_ready), 32'd1);
        chk("busy_after", 32'(o_busy), 32'd0);
        chk("valid_after", 32'(o_out_valid), 32'd0);
        i_in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_mode = 1'b0; i_in_valid = 1'b0; i_core_done = 1'b0;
        i_out_ready = 1'b0; i_in_real = 32'd0; i_in_imag = 32'd0;
        i_core_X_real = '0; i_core_X_imag = '0;
        repeat (3) step();
        chk("rst_in_ready", 32'(o_in_ready), 32'd1);
        chk("rst_start", 32'(o_core_start), 32'd0);
        chk("rst_valid", 32'(o_out_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_real", o_out_real, 32'd0);
        chk("rst_imag", o_out_imag, 32'd0);
        chk("rst_index", 32'(o_out_index), 32'd0);
        chk("rst_last", 32'(o_out_last), 32'd0);
        i_rst_n = 1'b1;
        step();

        // Forward impulse: a flat spectrum of 1.0.
        for (int k = 0; k < NP; k++) begin
            in_re[k] = (k == 0) ? 32'h3F800000 : 32'h0;
            in_im[k] = 32'h0;
            cx_re[k] = 32'h3F800000; cx_im[k] = 32'h0;
            exp_re[k] = 32'h3F800000; exp_im[k] = 32'h0;
        end
        send_frame(1'b0, 1'b0);
        core_respond(1'b0);
        recv(1'b0, 1'b0, -1);
        chk("one_start_pulse", 32'(start_cnt), 32'd1);

        // Inverse of an all-ones spectrum: bin 0 of 8.0 scales down to 1.0.
        for (int k = 0; k < NP; k++) begin
            in_re[k] = 32'h3F800000; in_im[k] = 32'h0;
            cx_re[k] = (k == 0) ? 32'h41000000 : 32'h0; cx_im[k] = 32'h0;
            exp_re[k] = (k == 0) ? 32'h3F800000 : 32'h0; exp_im[k] = 32'h80000000;
        end
        send_frame(1'b1, 1'b0);
        core_respond(1'b0);
        recv(1'b0, 1'b0, -1);

        // Backpressure, with input valid held high throughout the stall.
        for (int k = 0; k < NP; k++) begin
            in_re[k] = 32'h01000000 * k; in_im[k] = 32'h00000100 * k;
            cx_re[k] = 32'h40000000 + k; cx_im[k] = 32'hC0000000 + k;
            exp_re[k] = cx_re[k]; exp_im[k] = cx_im[k];
        end
        send_frame(1'b0, 1'b0);
        i_in_valid = 1'b1; i_in_real = 32'hDEADBEEF; i_in_imag = 32'hDEADBEEF;
        core_respond(1'b0);
        recv(1'b1, 1'b1, -1);

        // Inverse scaling boundaries; imaginary parts are also conjugated.
        cx_re[0] = 32'h00800000; exp_re[0] = 32'h00000000; exp_im[0] = 32'h80000000;
        cx_re[1] = 32'h80800000; exp_re[1] = 32'h80000000; exp_im[1] = 32'h00000000;
        cx_re[2] = 32'h41000000; exp_re[2] = 32'h3F800000; exp_im[2] = 32'hBF800000;
        cx_re[3] = 32'h7F800000; exp_re[3] = 32'h7F800000; exp_im[3] = 32'hFF800000;
        cx_re[4] = 32'h00000001; exp_re[4] = 32'h00000001; exp_im[4] = 32'h80000001;
        cx_re[5] = 32'h40800000; exp_re[5] = 32'h3F000000; exp_im[5] = 32'hBF000000;
        cx_re[6] = 32'h01800000; exp_re[6] = 32'h00000000; exp_im[6] = 32'h80000000;
        cx_re[7] = 32'h02000000; exp_re[7] = 32'h00800000; exp_im[7] = 32'h80800000;
        for (int k = 0; k < NP; k++) begin
            cx_im[k] = cx_re[k];
            in_re[k] = 32'h3F000000 + k; in_im[k] = 32'h00000010 + k;
        end
        send_frame(1'b1, 1'b0);
        core_respond(1'b0);
        recv(1'b0, 1'b0, -1);

        // Done held high across two frames, with a spurious pulse while collecting.
        for (int k = 0; k < NP; k++) begin
            in_re[k] = 32'h00000A00 + k; in_im[k] = 32'h00000B00 + k;
            cx_re[k] = 32'h3E000000 + k; cx_im[k] = 32'hBE000000 + k;
            exp_re[k] = cx_re[k]; exp_im[k] = cx_im[k];
        end
        send_frame(1'b0, 1'b1);
        core_respond(1'b1);
        recv(1'b0, 1'b0, -1);
        for (int k = 0; k < NP; k++) begin
            in_re[k] = 32'h00000C00 + k; in_im[k] = 32'h00000D00 + k;
            cx_re[k] = 32'h42000000 + k; cx_im[k] = 32'h43000000 + k;
            exp_re[k] = cx_re[k]; exp_im[k] = cx_im[k];
        end
        send_frame(1'b0, 1'b0);
        core_respond(1'b1);
        recv(1'b0, 1'b0, -1);
        i_core_done = 1'b0;

        // Reset while bin 3 is presented, then a clean frame afterwards.
        send_frame(1'b0, 1'b0);
        core_respond(1'b0);
        recv(1'b0, 1'b0, 3);
        chk("pre_rst_index", 32'(o_out_index), 32'd3);
        i_rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(o_out_valid), 32'd0);
        chk("midrst_in_ready", 32'(o_in_ready), 32'd1);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        i_rst_n = 1'b1;
        step();
        for (int k = 0; k < NP; k++) begin
            in_re[k] = 32'h00000E00 + k; in_im[k] = 32'h00000F00 + k;
            cx_re[k] = 32'h3D000000 + k; cx_im[k] = 32'h3C000000 + k;
            exp_re[k] = cx_re[k]; exp_im[k] = cx_im[k];
        end
        send_frame(1'b0, 1'b0);
        core_respond(1'b0);
        recv(1'b0, 1'b0, -1);
        chk("start_total", 32'(start_cnt), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
